// File: rtl/helios_multi_core_dispatcher.sv
// helios_multi_core_dispatcher
// Splits a host syndrome stream into fixed-length frames, hands each frame
// whole to the next enabled decoder core (round-robin), and merges the cores'
// result frames back to the host in the same order the frames were sent.
// A small tag FIFO records which core got each frame, and the result side
// uses it to decide which core it listens to next.

module helios_multi_core_dispatcher #(
  parameter int NUM_CORES       = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int IN_FRAME_WORDS  = 4,
  parameter int OUT_FRAME_WORDS = 2,
  parameter int TAG_FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            core_enable,
  input  logic [DATA_WIDTH-1:0]           s_data,
  input  logic                            s_valid,
  output logic                            s_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_CORES*DATA_WIDTH-1:0] core_in_data,
  output logic [NUM_CORES-1:0]            core_in_valid,
  input  logic [NUM_CORES-1:0]            core_in_ready,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] core_out_data,
  input  logic [NUM_CORES-1:0]            core_out_valid,
  output logic [NUM_CORES-1:0]            core_out_ready,
  output logic [CNT_WIDTH-1:0]            frames_in,
  output logic [CNT_WIDTH-1:0]            frames_out,
  output logic                            idle
);

  localparam int SEL_W  = $clog2(NUM_CORES);
  localparam int PTR_W  = $clog2(TAG_FIFO_DEPTH);
  localparam int WCNT_W = (IN_FRAME_WORDS > 1) ? $clog2(IN_FRAME_WORDS) : 1;
  localparam int OCNT_W = (OUT_FRAME_WORDS > 1) ? $clog2(OUT_FRAME_WORDS) : 1;

  localparam logic [WCNT_W-1:0] IN_LAST  = WCNT_W'(IN_FRAME_WORDS - 1);
  localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_FRAME_WORDS - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(NUM_CORES - 1);

  typedef enum logic {D_SELECT, D_SEND} in_state_t;
  typedef enum logic {C_WAIT, C_RECV}   out_state_t;

  // Input side state
  in_state_t         in_state, in_state_nxt;
  logic [SEL_W-1:0]  in_sel;
  logic [SEL_W-1:0]  rr_ptr;
  logic [WCNT_W-1:0] word_cnt;
  logic              push;
  logic              in_xfer;
  logic              in_done;

  // Candidate search results
  logic [SEL_W-1:0]  cand;
  logic [SEL_W-1:0]  cand_hi;
  logic [SEL_W-1:0]  cand_any;
  logic              cand_found_hi;
  logic              cand_valid;

  // Output side state
  out_state_t        out_state, out_state_nxt;
  logic [SEL_W-1:0]  out_sel;
  logic [OCNT_W-1:0] out_cnt;
  logic              pop;
  logic              out_xfer;
  logic              out_load;
  logic [DATA_WIDTH-1:0] out_slice [NUM_CORES];

  // Tag FIFO: one extra pointer bit separates full from empty
  logic [SEL_W-1:0]  tag_mem [TAG_FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty;
  logic [SEL_W-1:0]  fifo_head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_head  = tag_mem[rd_ptr[PTR_W-1:0]];

  // Every core sees the host word; only the selected core's valid is raised.
  assign core_in_data = {NUM_CORES{s_data}};

  assign idle = (in_state == D_SELECT) && (out_state == C_WAIT) && fifo_empty;

  // Pick the first enabled core after rr_ptr, wrapping around to the lowest
  // enabled index when nothing above rr_ptr is enabled.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cand_hi       = '0;
    cand_any      = '0;
    cand_found_hi = 1'b0;
    cand_valid    = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (core_enable[k]) begin
        cand_any   = SEL_W'(k);
        cand_valid = 1'b1;
        if (SEL_W'(k) > rr_ptr) begin
          cand_hi       = SEL_W'(k);
          cand_found_hi = 1'b1;
        end
      end
    end
    cand = cand_found_hi ? cand_hi : cand_any;
  end

  // Input FSM next state and routing of the host stream to the selected core.
  always_comb begin
    in_state_nxt  = in_state;
    push          = 1'b0;
    in_xfer       = 1'b0;
    in_done       = 1'b0;
    s_ready       = 1'b0;
    core_in_valid = '0;
    case (in_state)
      D_SELECT: begin
        if (s_valid && cand_valid && !fifo_full) begin
          push         = 1'b1;
          in_state_nxt = D_SEND;
        end
      end
      D_SEND: begin
        s_ready               = core_in_ready[in_sel];
        core_in_valid[in_sel] = s_valid;
        in_xfer               = s_valid && core_in_ready[in_sel];
        if (in_xfer && (word_cnt == IN_LAST)) begin
          in_done      = 1'b1;
          in_state_nxt = D_SELECT;
        end
      end
      default: in_state_nxt = D_SELECT;
    endcase
  end

  // Input FSM registers: state, selected core, round-robin pointer, counters.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      in_state  <= D_SELECT;
      in_sel    <= '0;
      rr_ptr    <= SEL_LAST;
      word_cnt  <= '0;
      frames_in <= '0;
    end else begin
      in_state <= in_state_nxt;
      if (push) begin
        in_sel   <= cand;
        rr_ptr   <= cand;
        word_cnt <= '0;
      end else if (in_xfer) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (in_done) begin
        frames_in <= frames_in + 1'b1;
      end
    end
  end

  // Unpack the flat core result bus into per-core slices.
  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      out_slice[k] = core_out_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output FSM next state and result path from the head-of-line core.
  always_comb begin
    out_state_nxt  = out_state;
    out_load       = 1'b0;
    out_xfer       = 1'b0;
    pop            = 1'b0;
    m_valid        = 1'b0;
    m_data         = '0;
    core_out_ready = '0;
    case (out_state)
      C_WAIT: begin
        if (!fifo_empty) begin
          out_load      = 1'b1;
          out_state_nxt = C_RECV;
        end
      end
      C_RECV: begin
        m_valid                 = core_out_valid[out_sel];
        m_data                  = out_slice[out_sel];
        core_out_ready[out_sel] = m_ready;
        out_xfer                = core_out_valid[out_sel] && m_ready;
        if (out_xfer && (out_cnt == OUT_LAST)) begin
          pop           = 1'b1;
          out_state_nxt = C_WAIT;
        end
      end
      default: out_state_nxt = C_WAIT;
    endcase
  end

  // Output FSM registers: state, core being drained, word and frame counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_state  <= C_WAIT;
      out_sel    <= '0;
      out_cnt    <= '0;
      frames_out <= '0;
    end else begin
      out_state <= out_state_nxt;
      if (out_load) begin
        out_sel <= fifo_head;
        out_cnt <= '0;
      end else if (out_xfer) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (pop) begin
        frames_out <= frames_out + 1'b1;
      end
    end
  end

  // Tag FIFO pointers; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Tag FIFO storage, written on every dispatch.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, so stale contents are never observed.
    if (push) begin
      tag_mem[wr_ptr[PTR_W-1:0]] <= cand;
    end
  end

endmodule
